// File: rtl/pakout_pkg.sv
// -----------------------------------------------------------------------------
// pakout_pkg
//   Shared constants and size helpers for the packet-out serializer.
//   - RX_* / TX_* : state encodings of the message-receive and packet-send FSMs
//   - msg_size()  : width of one assembled message {red,dat,dst,src}
//   - tot_pks()   : packets per message (message width rounded up to PSZ)
//   - idx_width() : width of the packet index (never below 1 bit)
//   - addr_width(): FIFO address width for a power-of-2 depth
// -----------------------------------------------------------------------------
package pakout_pkg;

   localparam logic [1:0] RX_IDLE = 2'd0;
   localparam logic [1:0] RX_REL  = 2'd1;

   localparam logic [1:0] TX_IDLE = 2'd0;
   localparam logic [1:0] TX_REQ  = 2'd1;
   localparam logic [1:0] TX_REL  = 2'd2;

   function automatic int msg_size(input int asz, input int dsz, input int rsz);
      return 2 * asz + dsz + rsz;
   endfunction

   function automatic int tot_pks(input int msg_sz, input int psz);
      return (msg_sz + psz - 1) / psz;
   endfunction

   function automatic int idx_width(input int tot);
      return (tot > 1) ? $clog2(tot) : 1;
   endfunction

   function automatic int addr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/pakout_fifo.sv
// -----------------------------------------------------------------------------
// pakout_fifo
//   Synchronous message FIFO with wrap-around pointers (one extra MSB tells
//   full from empty). Head entry is read combinationally so the consumer can
//   pop and capture the message on the same edge.
//   Ports:
//     clk      in   clock, all state on rising edge
//     rst_n    in   asynchronous active-low reset (empties the FIFO)
//     i_push   in   write i_data (ignored when full)
//     i_data   in   W-bit entry to write
//     i_pop    in   drop head entry (ignored when empty)
//     o_data   out  current head entry
//     o_full   out  DEPTH entries stored
//     o_empty  out  no entries stored
// -----------------------------------------------------------------------------
module pakout_fifo
   import pakout_pkg::*;
#(
   parameter int W     = 48,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_push,
   input  logic [W-1:0] i_data,
   input  logic         i_pop,
   output logic [W-1:0] o_data,
   output logic         o_full,
   output logic         o_empty
);

   localparam int AW = addr_width(DEPTH);

   logic [W-1:0] r_mem [DEPTH];
   logic [AW:0]  r_wr_ptr;
   logic [AW:0]  r_rd_ptr;
   logic         w_wr_en;
   logic         w_rd_en;

   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

   assign w_wr_en = i_push && !o_full;
   assign w_rd_en = i_pop && !o_empty;

   // Storage carries no reset: pointer reset alone discards the contents.
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem[r_wr_ptr[AW-1:0]] <= i_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_wr_en) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_rd_en) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
      end
   end

   assign o_data = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/pakout.sv
// -----------------------------------------------------------------------------
// pakout
//   Packet-link serializer. Accepts whole messages {src,dst,dat,red} on a
//   4-phase req/ack message channel, queues them, and sends each as TOT_PKS
//   packets of PSZ bits (LSB packet first) on a 4-phase packet channel.
//   Ports:
//     gch_clk    in   clock
//     gch_reset  in   asynchronous active-low reset
//     gch_ready  out  initialised and synchronizers settled
//     rcv0_src/dst/dat/red  in   message fields (src lands in the LSBs)
//     rcv0_req   in   message request        rcv0_ack  out  message acknowledge
//     snd0_pck   out  packet payload         snd0_idx  out  packet index, 0 first
//     snd0_last  out  high on final packet   snd0_req  out  packet request
//     snd0_ack   in   packet acknowledge
// -----------------------------------------------------------------------------
module pakout
   import pakout_pkg::*;
#(
   parameter  int PSZ     = 8,
   parameter  int FSZ     = 4,
   parameter  int ASZ     = 6,
   parameter  int DSZ     = 32,
   parameter  int RSZ     = 4,
   parameter  int SYN_CKS = 2,
   localparam int MSG_SZ  = msg_size(ASZ, DSZ, RSZ),
   localparam int TOT_PKS = tot_pks(MSG_SZ, PSZ),
   localparam int IDX_W   = idx_width(TOT_PKS)
) (
   input  logic             gch_clk,
   input  logic             gch_reset,
   output logic             gch_ready,
   input  logic [ASZ-1:0]   rcv0_src,
   input  logic [ASZ-1:0]   rcv0_dst,
   input  logic [DSZ-1:0]   rcv0_dat,
   input  logic [RSZ-1:0]   rcv0_red,
   input  logic             rcv0_req,
   output logic             rcv0_ack,
   output logic [PSZ-1:0]   snd0_pck,
   output logic [IDX_W-1:0] snd0_idx,
   output logic             snd0_last,
   output logic             snd0_req,
   input  logic             snd0_ack
);

   localparam int SH_W  = TOT_PKS * PSZ;
   localparam int CNT_W = $clog2(SYN_CKS + 1);

   logic [SYN_CKS-1:0] r_req_sync;
   logic [SYN_CKS-1:0] r_ack_sync;
   logic               w_req_s;
   logic               w_ack_s;

   logic [CNT_W-1:0]   r_rdy_cnt;
   logic               r_ready;

   logic [1:0]         r_rx_state;
   logic               r_rcv_ack;

   logic [1:0]         r_tx_state;
   logic               r_snd_req;
   logic               r_last;
   logic [IDX_W-1:0]   r_idx;
   logic [SH_W-1:0]    r_shift;

   logic [MSG_SZ-1:0]  w_msg;
   logic [MSG_SZ-1:0]  w_head;
   logic               w_push;
   logic               w_pop;
   logic               w_full;
   logic               w_empty;

   assign w_req_s = r_req_sync[SYN_CKS-1];
   assign w_ack_s = r_ack_sync[SYN_CKS-1];

   assign w_msg = {rcv0_red, rcv0_dat, rcv0_dst, rcv0_src};

   // Push is gated on the registered full flag, so a pop in the same cycle
   // as full does not open a slot until the next cycle.
   assign w_push = r_ready && (r_rx_state == RX_IDLE) && w_req_s && !w_full;
   assign w_pop  = r_ready && (r_tx_state == TX_IDLE) && !w_empty;

   // Input synchronizers for the two asynchronous handshake inputs.
   always_ff @(posedge gch_clk or negedge gch_reset) begin
      if (!gch_reset) begin
         r_req_sync <= '0;
         r_ack_sync <= '0;
      end else begin
         r_req_sync <= {r_req_sync[SYN_CKS-2:0], rcv0_req};
         r_ack_sync <= {r_ack_sync[SYN_CKS-2:0], snd0_ack};
      end
   end

   // Ready once the synchronizer chains have been flushed with real samples.
   always_ff @(posedge gch_clk or negedge gch_reset) begin
      if (!gch_reset) begin
         r_rdy_cnt <= '0;
         r_ready   <= 1'b0;
      end else begin
         if (r_rdy_cnt != CNT_W'(SYN_CKS)) begin
            r_rdy_cnt <= r_rdy_cnt + 1'b1;
         end
         r_ready <= (r_rdy_cnt == CNT_W'(SYN_CKS));
      end
   end

   // Message receive: one FIFO push per complete 4-phase handshake.
   always_ff @(posedge gch_clk or negedge gch_reset) begin
      if (!gch_reset) begin
         r_rx_state <= RX_IDLE;
         r_rcv_ack  <= 1'b0;
      end else begin
         case (r_rx_state)
            RX_IDLE: begin
               if (w_push) begin
                  r_rcv_ack  <= 1'b1;
                  r_rx_state <= RX_REL;
               end
            end
            RX_REL: begin
               if (!w_req_s) begin
                  r_rcv_ack  <= 1'b0;
                  r_rx_state <= RX_IDLE;
               end
            end
            default: begin
               r_rcv_ack  <= 1'b0;
               r_rx_state <= RX_IDLE;
            end
         endcase
      end
   end

   // Packet send: payload/idx/last only move on TX_REL -> TX_REQ, i.e. after
   // the peer has released ack, so they are stable for the whole handshake.
   always_ff @(posedge gch_clk or negedge gch_reset) begin
      if (!gch_reset) begin
         r_tx_state <= TX_IDLE;
         r_snd_req  <= 1'b0;
         r_last     <= 1'b0;
         r_idx      <= '0;
         r_shift    <= '0;
      end else begin
         case (r_tx_state)
            TX_IDLE: begin
               if (w_pop) begin
                  r_shift    <= SH_W'(w_head);
                  r_idx      <= '0;
                  r_last     <= (TOT_PKS == 1);
                  r_tx_state <= TX_REQ;
               end
            end
            TX_REQ: begin
               r_snd_req <= 1'b1;
               if (r_snd_req && w_ack_s) begin
                  r_snd_req  <= 1'b0;
                  r_tx_state <= TX_REL;
               end
            end
            TX_REL: begin
               if (!w_ack_s) begin
                  if (r_last) begin
                     r_tx_state <= TX_IDLE;
                  end else begin
                     r_idx      <= r_idx + 1'b1;
                     r_shift    <= r_shift >> PSZ;
                     r_last     <= (int'(r_idx) + 2 == TOT_PKS);
                     r_tx_state <= TX_REQ;
                  end
               end
            end
            default: begin
               r_snd_req  <= 1'b0;
               r_tx_state <= TX_IDLE;
            end
         endcase
      end
   end

   pakout_fifo #(
      .W     (MSG_SZ),
      .DEPTH (FSZ)
   ) u_fifo (
      .clk     (gch_clk),
      .rst_n   (gch_reset),
      .i_push  (w_push),
      .i_data  (w_msg),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign gch_ready = r_ready;
   assign rcv0_ack  = r_rcv_ack;
   assign snd0_pck  = r_shift[PSZ-1:0];
   assign snd0_idx  = r_idx;
   assign snd0_last = r_last;
   assign snd0_req  = r_snd_req;

endmodule

// File: tb/tb_pakout.sv
`timescale 1ns/1ps
module tb_pakout;

   typedef struct packed {
      logic [7:0] pck;
      logic [2:0] idx;
      logic       last;
   } pkt_t;

   typedef struct {
      logic [5:0]       src;
      logic [5:0]       dst;
      logic [31:0]      dat;
      logic [3:0]       red;
      logic [5:0][7:0]  exp_pk;   // expected packet k in exp_pk[k]
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        ready;
   logic [5:0]  rcv_src;
   logic [5:0]  rcv_dst;
   logic [31:0] rcv_dat;
   logic [3:0]  rcv_red;
   logic        rcv_req;
   logic        rcv_ack;
   logic [7:0]  snd_pck;
   logic [2:0]  snd_idx;
   logic        snd_last;
   logic        snd_req;
   logic        snd_ack;

   logic        p5_ready;
   logic        p5_rreq;
   logic        p5_rack;
   logic [4:0]  p5_pck;
   logic [3:0]  p5_idx;
   logic        p5_last;
   logic        p5_sreq;
   logic        p5_sack;

   pakout #(.PSZ(8), .FSZ(4), .ASZ(6), .DSZ(32), .RSZ(4), .SYN_CKS(2)) u_dut (
      .gch_clk   (clk),
      .gch_reset (rst_n),
      .gch_ready (ready),
      .rcv0_src  (rcv_src),
      .rcv0_dst  (rcv_dst),
      .rcv0_dat  (rcv_dat),
      .rcv0_red  (rcv_red),
      .rcv0_req  (rcv_req),
      .rcv0_ack  (rcv_ack),
      .snd0_pck  (snd_pck),
      .snd0_idx  (snd_idx),
      .snd0_last (snd_last),
      .snd0_req  (snd_req),
      .snd0_ack  (snd_ack)
   );

   pakout #(.PSZ(5), .FSZ(4), .ASZ(6), .DSZ(32), .RSZ(4), .SYN_CKS(2)) u_p5 (
      .gch_clk   (clk),
      .gch_reset (rst_n),
      .gch_ready (p5_ready),
      .rcv0_src  (rcv_src),
      .rcv0_dst  (rcv_dst),
      .rcv0_dat  (rcv_dat),
      .rcv0_red  (rcv_red),
      .rcv0_req  (p5_rreq),
      .rcv0_ack  (p5_rack),
      .snd0_pck  (p5_pck),
      .snd0_idx  (p5_idx),
      .snd0_last (p5_last),
      .snd0_req  (p5_sreq),
      .snd0_ack  (p5_sack)
   );

   pkt_t sb[$];
   int   n_vec    = 0;
   int   n_err    = 0;
   int   n_pkts   = 0;
   int   dly_max  = 0;
   int   hold_idx = -1;
   logic hold_all = 1'b0;
   vec_t tbl[7];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk_vec(input logic [5:0] s, input logic [5:0] d,
                                   input logic [31:0] dt, input logic [3:0] r);
      vec_t v;
      v.src = s; v.dst = d; v.dat = dt; v.red = r;
      v.exp_pk = {r, dt, d, s};
      return v;
   endfunction

   function automatic logic [4:0] p5_model(input vec_t v, input int k);
      logic [49:0] m;
      m = {2'b00, v.red, v.dat, v.dst, v.src};
      m = m >> (5 * k);
      return m[4:0];
   endfunction

   task automatic push_exp(input vec_t v);
      for (int k = 0; k < 6; k++) sb.push_back(pkt_t'{v.exp_pk[k], 3'(k), (k == 5)});
   endtask

   task automatic drive_fields(input vec_t v);
      rcv_src = v.src; rcv_dst = v.dst; rcv_dat = v.dat; rcv_red = v.red;
   endtask

   task automatic send_msg(input vec_t v);
      push_exp(v);
      @(negedge clk);
      drive_fields(v);
      rcv_req = 1'b1;
      for (int c = 0; c < 3000 && !rcv_ack; c++) @(negedge clk);
      check("rcv_ack_rise", rcv_ack, 1);
      rcv_req = 1'b0;
      for (int c = 0; c < 3000 && rcv_ack; c++) @(negedge clk);
      check("rcv_ack_fall", rcv_ack, 0);
   endtask

   task automatic wait_drain();
      for (int c = 0; c < 20000 && (sb.size() != 0 || snd_req || snd_ack); c++) @(negedge clk);
      check("drain", sb.size(), 0);
   endtask

   // Packet-channel peer: checks each packet at req rise against the
   // scoreboard, then acks after a random delay, watching stability.
   initial begin : responder
      int   rs;
      int   cnt;
      pkt_t cap;
      pkt_t e;
      logic bad;
      rs = 0; cnt = 0; bad = 1'b0; snd_ack = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            snd_ack = 1'b0;
            rs = 0;
         end else begin
            if (rs != 0 && !bad && pkt_t'{snd_pck, snd_idx, snd_last} !== cap) begin
               bad = 1'b1;
               n_err++;
               $display("FAIL pkt_stable: got 0x%0h expected 0x%0h", pkt_t'{snd_pck, snd_idx, snd_last}, cap);
            end
            case (rs)
               0: if (snd_req && !snd_ack) begin
                     cap = pkt_t'{snd_pck, snd_idx, snd_last};
                     if (sb.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_pkt: got 0x%0h expected none", cap);
                     end else begin
                        e = sb.pop_front();
                        check("pkt", cap, e);
                     end
                     n_pkts++;
                     bad = 1'b0;
                     cnt = (dly_max > 0) ? int'($urandom_range(0, dly_max)) : 0;
                     rs  = 1;
                  end
               1: if (!(hold_all || int'(snd_idx) == hold_idx)) begin
                     if (cnt == 0) begin
                        snd_ack = 1'b1;
                        rs = 2;
                     end else cnt--;
                  end
               2: if (!snd_req) begin
                     cnt = (dly_max > 0) ? int'($urandom_range(0, dly_max)) : 0;
                     rs = 3;
                  end
               default: if (cnt == 0) begin
                     snd_ack = 1'b0;
                     rs = 0;
                  end else cnt--;
            endcase
         end
      end
   end

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "simulation timeout");
   end

   initial begin : main
      vec_t v;
      logic seen;
      int   c;
      int   pk0;

      tbl[0] = '{6'h01, 6'h02, 32'hDEADBEEF, 4'hA, {8'hAD, 8'hEA, 8'hDB, 8'hEE, 8'hF0, 8'h81}};
      tbl[1] = '{6'h00, 6'h00, 32'h00000000, 4'h0, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
      tbl[2] = '{6'h3F, 6'h3F, 32'hFFFFFFFF, 4'hF, {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF}};
      tbl[3] = '{6'h3F, 6'h00, 32'h00000000, 4'h0, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h3F}};
      tbl[4] = '{6'h00, 6'h3F, 32'h00000000, 4'h0, {8'h00, 8'h00, 8'h00, 8'h00, 8'h0F, 8'hC0}};
      tbl[5] = '{6'h00, 6'h00, 32'h12345678, 4'h0, {8'h01, 8'h23, 8'h45, 8'h67, 8'h80, 8'h00}};
      tbl[6] = '{6'h00, 6'h00, 32'h00000000, 4'hF, {8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};

      rst_n = 1'b0; rcv_req = 1'b0; p5_rreq = 1'b0; p5_sack = 1'b0;
      rcv_src = '0; rcv_dst = '0; rcv_dat = '0; rcv_red = '0;
      repeat (3) @(negedge clk);
      check("reset_outs", {ready, rcv_ack, snd_pck, snd_idx, snd_last, snd_req}, 0);
      check("reset_p5", {p5_ready, p5_rack, p5_pck, p5_idx, p5_last, p5_sreq}, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("ready_early", ready, 0);
      @(negedge clk);
      check("ready_rise", ready, 1);

      // First message: accept-to-request latency of two cycles.
      push_exp(tbl[0]);
      drive_fields(tbl[0]);
      rcv_req = 1'b1;
      for (c = 0; c < 50 && !rcv_ack; c++) @(negedge clk);
      check("acc_ack", rcv_ack, 1);
      for (c = 0; c < 20 && !snd_req; c++) @(negedge clk);
      check("latency", c, 2);
      rcv_req = 1'b0;
      for (c = 0; c < 50 && rcv_ack; c++) @(negedge clk);
      check("acc_ack_fall", rcv_ack, 0);
      wait_drain();

      // Table vectors with varying ack delays.
      for (int i = 1; i < 7; i++) begin
         dly_max = i % 4;
         send_msg(tbl[i]);
      end
      wait_drain();

      // PSZ=5 instance: ten packets, top packet zero-padded.
      v = tbl[0];
      @(negedge clk);
      drive_fields(v);
      p5_rreq = 1'b1;
      for (c = 0; c < 50 && !p5_rack; c++) @(negedge clk);
      check("p5_rcv_ack", p5_rack, 1);
      p5_rreq = 1'b0;
      for (c = 0; c < 50 && p5_rack; c++) @(negedge clk);
      for (int k = 0; k < 10; k++) begin
         for (c = 0; c < 50 && !p5_sreq; c++) @(negedge clk);
         check("p5_pkt", {p5_sreq, p5_pck, p5_idx, p5_last}, {1'b1, p5_model(v, k), 4'(k), (k == 9)});
         if (k == 9) check("p5_pad", p5_pck[4:3], 2'b00);
         p5_sack = 1'b1;
         for (c = 0; c < 50 && p5_sreq; c++) @(negedge clk);
         p5_sack = 1'b0;
      end

      // Backpressure: 1 message in the shifter + 4 in the FIFO, 6th refused.
      dly_max = 0;
      hold_all = 1'b1;
      for (int i = 0; i < 5; i++) send_msg(mk_vec(6'(i), 6'(i + 8), 32'hA5000000 + i, 4'(i)));
      v = mk_vec(6'h15, 6'h2A, 32'hCAFEF00D, 4'h6);
      push_exp(v);
      @(negedge clk);
      drive_fields(v);
      rcv_req = 1'b1;
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (rcv_ack) seen = 1'b1;
      end
      check("bp_hold", seen, 0);
      pk0 = n_pkts;
      hold_all = 1'b0;
      for (c = 0; c < 3000 && !rcv_ack; c++) @(negedge clk);
      check("bp_ack", rcv_ack, 1);
      check("bp_after_first", (n_pkts - pk0) >= 5, 1);
      rcv_req = 1'b0;
      for (c = 0; c < 100 && rcv_ack; c++) @(negedge clk);
      wait_drain();

      // Simultaneous push/pop with the FIFO partly full.
      pk0 = n_pkts;
      hold_all = 1'b1;
      for (int i = 0; i < 4; i++) send_msg(mk_vec(6'(i + 20), 6'(i + 40), 32'h3C3C0000 + i, 4'(i + 3)));
      hold_all = 1'b0;
      for (int i = 0; i < 4; i++) send_msg(mk_vec(6'(i + 30), 6'(i + 50), 32'h96960000 + i, 4'(i + 9)));
      wait_drain();
      check("pp_pkts", n_pkts - pk0, 48);

      // Random traffic with random ack delays.
      dly_max = 7;
      for (int i = 0; i < 100; i++) begin
         send_msg(mk_vec(6'($urandom), 6'($urandom), $urandom, 4'($urandom)));
      end
      wait_drain();

      // Reset while packet 3 is outstanding and a second message is acked.
      dly_max = 0;
      hold_idx = 3;
      send_msg(mk_vec(6'h11, 6'h22, 32'h01234567, 4'h9));
      for (c = 0; c < 500 && !(snd_req && snd_idx == 3); c++) @(negedge clk);
      check("reach_pkt3", {snd_req, snd_idx}, {1'b1, 3'd3});
      drive_fields(mk_vec(6'h33, 6'h0C, 32'hBADC0DE5, 4'h5));
      rcv_req = 1'b1;
      for (c = 0; c < 50 && !rcv_ack; c++) @(negedge clk);
      check("b_acked", rcv_ack, 1);
      rst_n = 1'b0;
      #1;
      check("rst_snd_req", snd_req, 0);
      check("rst_rcv_ack", rcv_ack, 0);
      check("rst_ready", ready, 0);
      sb.delete();
      rcv_req = 1'b0;
      hold_idx = -1;
      @(negedge clk);
      rst_n = 1'b1;
      for (c = 0; c < 10 && !ready; c++) @(negedge clk);
      check("ready_again", ready, 1);
      pk0 = n_pkts;
      send_msg(mk_vec(6'h05, 6'h06, 32'h76543210, 4'h3));
      wait_drain();
      repeat (100) @(negedge clk);
      check("no_stale", n_pkts - pk0, 6);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
